// File: rtl/mux8_sched_pkg.sv
// Shared types and widths for the 8-input round-robin mux scheduler.
package mux8_sched_pkg;
    localparam int N_IN  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set bit of cand scanning ptr, ptr+1, ... mod 8.
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N_IN-1:0]  cand,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [SEL_W-1:0] k;

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        k     = ptr;
        for (int i = 0; i < N_IN; i++) begin
            // 3-bit addition wraps naturally, giving the modulo-8 scan order.
            k = ptr + SEL_W'(i);
            if (!found && cand[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end
endmodule

// File: rtl/mux8_rr_scheduler.sv
// Round-robin owner of a shared 8:1 mux: registered one-hot grant plus select bits,
// with each tenure capped at HOLD_MAX cycles.
module mux8_rr_scheduler
    import mux8_sched_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      req,
    input  logic            done,
    output logic            s0,
    output logic            s1,
    output logic            s2,
    output logic [7:0]      gnt,
    output logic            busy
);
    // Handshake: a requester holds req[k] high until it sees gnt[k]; while it owns the
    // mux it keeps req[k] high, and either done or dropping req[k] releases at that edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             rel;

    rr_pick8 u_pick (
        .cand  (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign rel = done | ~req[sel_q] | (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = N_IN'(1) << pick_idx;
                    cnt_d   = '0;
                    ptr_d   = pick_idx + SEL_W'(1);
                end
            end
            GRANT: begin
                if (!rel) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (pick_found) begin
                    // ptr already sits at owner+1, so the owner only wins again when alone.
                    sel_d = pick_idx;
                    gnt_d = N_IN'(1) << pick_idx;
                    cnt_d = '0;
                    ptr_d = pick_idx + SEL_W'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // busy is the FSM state itself, so the state is observable at the boundary.
    assign busy         = (state_q == GRANT);
    assign gnt          = gnt_q;
    assign {s2, s1, s0} = sel_q;
endmodule
